led_div_ctrl: RTL and testbench

Divider controller for the LED counter. It drives that block's `div_i`/`wren_i` write port from two requesters: an internal step sequencer that sweeps a table of divider values, and a host write port with req/ack handshake. The host has priority. Each write is a single-cycle `wren_o` pulse with `div_o` stable. The block sits between the register/PS interface and the LED counter instance, on the clk100 domain.

---
 rtl/led_pkg.sv | 7 +
 rtl/led_div_ctrl_if.sv | 9 +
 rtl/led_edge_cnt.sv | 37 +++
 rtl/led_div_ctrl.sv | 130 +++++++++++++
 tb/tb_led_div_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED divider controller.
package led_pkg;
  localparam int LED_DIV_W = 5;
  localparam logic [LED_DIV_W-1:0] LED_DIV_RST = 5'h7;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, HOST, REL} led_ctrl_state_t;
endpackage

// File: rtl/led_div_ctrl_if.sv
// Host write port of the LED divider controller: level request held until a one-cycle ack.
interface led_div_ctrl_if;
  logic                          host_req_i;
  logic [led_pkg::LED_DIV_W-1:0] host_div_i;
  logic                          host_ack_o;

  modport master (output host_req_i, host_div_i, input host_ack_o);
  modport slave  (input host_req_i, host_div_i, output host_ack_o);
endinterface

// File: rtl/led_edge_cnt.sv
// Rising-edge detector on led_int_i feeding a saturating hold counter with clear and done.
module led_edge_cnt #(
  parameter int HOLD_W = 8
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              led_int_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              done
);
  logic              led_q;
  logic              rise;
  logic [HOLD_W-1:0] cnt, cnt_nxt, hold_eff;

  assign rise     = led_int_i & ~led_q;
  assign hold_eff = (hold_i == '0) ? HOLD_W'(1) : hold_i;

  always_comb begin
    cnt_nxt = cnt;
    if (en_i && rise && (cnt != '1)) cnt_nxt = cnt + 1'b1;
  end

  // Compare against the post-edge count so the completing edge itself ends the hold.
  assign done = en_i && (cnt_nxt >= hold_eff);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
      cnt   <= '0;
    end else begin
      led_q <= led_int_i;
      cnt   <= clr_i ? '0 : cnt_nxt;
    end
  end
endmodule

// File: rtl/led_div_ctrl.sv
// Arbitrates the LED counter div/wren write port between a step sequencer and a host.
// Build option: LED_DIV_CTRL_PINGPONG_EN makes the sequencer bounce instead of wrap.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter  int NUM_STEPS = 4,
  parameter  int HOLD_W    = 8,
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                           clk100,
  input  logic                           rst_n,
  input  logic                           seq_en_i,
  input  logic [HOLD_W-1:0]              hold_i,
  input  logic [NUM_STEPS*LED_DIV_W-1:0] step_div_i,
  led_div_ctrl_if.slave                  host,
  input  logic                           led_int_i,
  output logic [LED_DIV_W-1:0]           div_o,
  output logic                           wren_o,
  output logic [STEP_W-1:0]              step_o,
  output logic                           busy_o
);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  led_ctrl_state_t       state, state_nxt;
  logic [STEP_W-1:0]     step_nxt, step_adv;
  logic [LED_DIV_W-1:0]  div_nxt, tbl_div;
  logic                  wren_nxt, ack_nxt, ack_q, hold_done;

  assign tbl_div       = step_div_i[LED_DIV_W*int'(step_o) +: LED_DIV_W];
  assign busy_o        = (state != IDLE);
  assign host.host_ack_o = ack_q;

  led_edge_cnt #(.HOLD_W(HOLD_W)) u_edge_cnt (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .led_int_i (led_int_i),
    .en_i      (state == HOLD),
    .clr_i     (state == LOAD),
    .hold_i    (hold_i),
    .done      (hold_done)
  );

`ifdef LED_DIV_CTRL_PINGPONG_EN
  logic dir_up, dir_nxt, dir_adv;

  always_comb begin
    step_adv = step_o;
    dir_adv  = dir_up;
    if (NUM_STEPS > 1) begin
      if (dir_up) begin
        if (step_o == STEP_LAST) begin
          step_adv = step_o - 1'b1;
          dir_adv  = 1'b0;
        end else step_adv = step_o + 1'b1;
      end else begin
        if (step_o == '0) begin
          step_adv = step_o + 1'b1;
          dir_adv  = 1'b1;
        end else step_adv = step_o - 1'b1;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) dir_up <= 1'b1;
    else        dir_up <= dir_nxt;
  end
`else
  always_comb begin
    step_adv = (step_o == STEP_LAST) ? '0 : step_o + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    step_nxt  = step_o;
    div_nxt   = div_o;
    wren_nxt  = 1'b0;
    ack_nxt   = 1'b0;
`ifdef LED_DIV_CTRL_PINGPONG_EN
    dir_nxt   = dir_up;
`endif
    unique case (state)
      IDLE: begin
        if (host.host_req_i) state_nxt = HOST;
        else if (seq_en_i)   state_nxt = LOAD;
      end
      LOAD: begin
        div_nxt   = tbl_div;
        wren_nxt  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        // Host preempts a coincident hold completion; the step stays put for the reload.
        if (host.host_req_i) state_nxt = HOST;
        else if (hold_done) begin
          step_nxt  = step_adv;
`ifdef LED_DIV_CTRL_PINGPONG_EN
          dir_nxt   = dir_adv;
`endif
          state_nxt = LOAD;
        end else if (!seq_en_i) state_nxt = IDLE;
      end
      HOST: begin
        div_nxt   = host.host_div_i;
        wren_nxt  = 1'b1;
        ack_nxt   = 1'b1;
        state_nxt = REL;
      end
      REL:     if (!host.host_req_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step_o <= '0;
      div_o  <= LED_DIV_RST;
      wren_o <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_o <= step_nxt;
      div_o  <= div_nxt;
      wren_o <= wren_nxt;
      ack_q  <= ack_nxt;
    end
  end
endmodule

// File: tb/tb_led_div_ctrl.sv
// Directed bench for led_div_ctrl: sequencer sweep, host arbitration, reset and step order.
module tb_led_div_ctrl;
  localparam int NS = 4;

  logic          clk100;
  logic          rst_n, seq_en_i, led_int_i;
  logic [7:0]    hold_i;
  logic [NS*5-1:0] step_div_i;
  logic [4:0]    div_o;
  logic          wren_o, busy_o;
  logic [1:0]    step_o;

  led_div_ctrl_if hif();

  led_div_ctrl #(.NUM_STEPS(NS), .HOLD_W(8)) dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .seq_en_i   (seq_en_i),
    .hold_i     (hold_i),
    .step_div_i (step_div_i),
    .host       (hif),
    .led_int_i  (led_int_i),
    .div_o      (div_o),
    .wren_o     (wren_o),
    .step_o     (step_o),
    .busy_o     (busy_o)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  int checks, errors;
  bit led_run, pend, hit, b2b, wren_prev;
  int led_ph, hits, last_rises;

  // One cycle: sample at negedge, track led_int rises seen by HOLD edges, advance led_int.
  task automatic tick();
    logic nxt;
    @(negedge clk100);
    hit = pend;
    if (wren_o && wren_prev) b2b = 1'b1;
    wren_prev = wren_o;
    if (wren_o) begin
      last_rises = hits;
      hits = 0;
    end else if (hit) hits++;
    pend = 1'b0;
    if (led_run) begin
      led_ph++;
      nxt = ((led_ph / 4) % 2) == 1;
      pend = nxt && !led_int_i;
      led_int_i = nxt;
    end
  endtask

  task automatic wait_pulse(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (wren_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seq_en_i = 1'b0; hold_i = '0; step_div_i = '0; led_int_i = 1'b0;
    hif.host_req_i = 1'b0; hif.host_div_i = '0; led_run = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({div_o, wren_o, busy_o, step_o, hif.host_ack_o} !== {5'h7, 1'b0, 1'b0, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc %0d: got div=%0h wren=%b busy=%b step=%0d ack=%b, want div=7 wren=0 busy=0 step=0 ack=0",
                 c, div_o, wren_o, busy_o, step_o, hif.host_ack_o);
      end
    end
  endtask

  task automatic test_seq();
    logic [4:0] exp_div[6];
    logic [1:0] exp_step[6];
    bit ok;
`ifdef LED_DIV_CTRL_PINGPONG_EN
    exp_div = '{5'd3, 5'd5, 5'd9, 5'd17, 5'd9, 5'd5};
    exp_step = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
`else
    exp_div = '{5'd3, 5'd5, 5'd9, 5'd17, 5'd3, 5'd5};
    exp_step = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
    step_div_i = {5'd17, 5'd9, 5'd5, 5'd3};
    hold_i = 8'd2; led_run = 1'b1; seq_en_i = 1'b1;
    tick();
    checks++;
    if (wren_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL seq_load: got wren=%b busy=%b, want wren=0 busy=1", wren_o, busy_o);
    end
    tick();
    checks++;
    if (wren_o !== 1'b1 || div_o !== 5'd3 || step_o !== 2'd0) begin
      errors++; $display("FAIL seq_first: got wren=%b div=%0d step=%0d, want wren=1 div=3 step=0", wren_o, div_o, step_o);
    end
    for (int p = 1; p < 6; p++) begin
      wait_pulse(200, ok);
      checks++;
      if (!ok || div_o !== exp_div[p] || step_o !== exp_step[p] || last_rises != 2) begin
        errors++;
        $display("FAIL seq_pulse %0d: got ok=%b div=%0d step=%0d rises=%0d, want div=%0d step=%0d rises=2",
                 p, ok, div_o, step_o, last_rises, exp_div[p], exp_step[p]);
      end
    end
  endtask

  task automatic test_host_coincide();
    bit found, ok;
    found = 1'b0;
    hif.host_div_i = 5'h11;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (pend && hits == 1 && !wren_o) begin
        hif.host_req_i = 1'b1;
        found = 1'b1;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL coincide_setup: got no completing edge, want one within 100 cycles"); end
    tick();
    checks++;
    if (wren_o !== 1'b0 || hif.host_ack_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL coincide_gap: got wren=%b ack=%b busy=%b, want 0 0 1", wren_o, hif.host_ack_o, busy_o);
    end
    tick();
    checks++;
    if (wren_o !== 1'b1 || hif.host_ack_o !== 1'b1 || div_o !== 5'h11) begin
      errors++; $display("FAIL coincide_write: got wren=%b ack=%b div=%0h, want 1 1 11", wren_o, hif.host_ack_o, div_o);
    end
    hif.host_req_i = 1'b0;
    wait_pulse(100, ok);
    checks++;
    if (!ok || div_o !== 5'd5 || step_o !== 2'd1 || hif.host_ack_o !== 1'b0) begin
      errors++; $display("FAIL coincide_reload: got ok=%b div=%0d step=%0d ack=%b, want div=5 step=1 ack=0",
                         ok, div_o, step_o, hif.host_ack_o);
    end
  endtask

  task automatic test_host_hold();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6 && !(ok && step_o == 2'd2); i++) wait_pulse(100, ok);
    checks++;
    if (!ok || div_o !== 5'd9) begin errors++; $display("FAIL host_reach_step2: got ok=%b div=%0d, want div=9", ok, div_o); end
    tick(); tick();
    hif.host_req_i = 1'b1; hif.host_div_i = 5'h1F;
    tick();
    checks++;
    if (wren_o !== 1'b0 || hif.host_ack_o !== 1'b0) begin
      errors++; $display("FAIL host_gap: got wren=%b ack=%b, want 0 0", wren_o, hif.host_ack_o);
    end
    tick();
    checks++;
    if (wren_o !== 1'b1 || hif.host_ack_o !== 1'b1 || div_o !== 5'h1F) begin
      errors++; $display("FAIL host_write: got wren=%b ack=%b div=%0h, want 1 1 1f", wren_o, hif.host_ack_o, div_o);
    end
    hif.host_req_i = 1'b0;
    tick();
    checks++;
    if (wren_o !== 1'b0 || hif.host_ack_o !== 1'b0 || div_o !== 5'h1F) begin
      errors++; $display("FAIL host_single: got wren=%b ack=%b div=%0h, want 0 0 1f", wren_o, hif.host_ack_o, div_o);
    end
    wait_pulse(100, ok);
    checks++;
    if (!ok || div_o !== 5'd9 || step_o !== 2'd2) begin
      errors++; $display("FAIL host_reload: got ok=%b div=%0d step=%0d, want div=9 step=2", ok, div_o, step_o);
    end
  endtask

  task automatic test_disable();
    bit ok;
    seq_en_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (wren_o !== 1'b0 || busy_o !== 1'b0 || step_o !== 2'd2) begin
        errors++; $display("FAIL disable_idle %0d: got wren=%b busy=%b step=%0d, want 0 0 2", c, wren_o, busy_o, step_o);
      end
    end
    seq_en_i = 1'b1;
    tick();
    wait_pulse(3, ok);
    checks++;
    if (!ok || div_o !== 5'd9 || step_o !== 2'd2) begin
      errors++; $display("FAIL disable_resume: got ok=%b div=%0d step=%0d, want div=9 step=2", ok, div_o, step_o);
    end
  endtask

  task automatic test_protocol();
    hif.host_req_i = 1'b1; hif.host_div_i = 5'h0A;
    tick();
    hif.host_req_i = 1'b0;
    tick();
    checks++;
    if (wren_o !== 1'b1 || hif.host_ack_o !== 1'b1 || div_o !== 5'h0A) begin
      errors++; $display("FAIL proto_write: got wren=%b ack=%b div=%0h, want 1 1 a", wren_o, hif.host_ack_o, div_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || wren_o !== 1'b0) begin
      errors++; $display("FAIL proto_rel_exit: got busy=%b wren=%b, want 0 0", busy_o, wren_o);
    end
    tick(); tick();
    checks++;
    if (wren_o !== 1'b1 || div_o !== 5'd9 || step_o !== 2'd2) begin
      errors++; $display("FAIL proto_reload: got wren=%b div=%0d step=%0d, want 1 9 2", wren_o, div_o, step_o);
    end
  endtask

  task automatic test_hold_zero();
    logic [4:0] exp_div[3];
    logic [1:0] exp_step[3];
    bit ok;
`ifdef LED_DIV_CTRL_PINGPONG_EN
    exp_div = '{5'd17, 5'd9, 5'd5};
    exp_step = '{2'd3, 2'd2, 2'd1};
`else
    exp_div = '{5'd17, 5'd3, 5'd5};
    exp_step = '{2'd3, 2'd0, 2'd1};
`endif
    hold_i = 8'd0;
    for (int p = 0; p < 3; p++) begin
      wait_pulse(100, ok);
      checks++;
      if (!ok || div_o !== exp_div[p] || step_o !== exp_step[p] || last_rises != 1) begin
        errors++;
        $display("FAIL hold_zero %0d: got ok=%b div=%0d step=%0d rises=%0d, want div=%0d step=%0d rises=1",
                 p, ok, div_o, step_o, last_rises, exp_div[p], exp_step[p]);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    wait_pulse(100, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || wren_o !== 1'b0 || div_o !== 5'h7 || step_o !== 2'd0 || busy_o !== 1'b0 || hif.host_ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got ok=%b wren=%b div=%0h step=%0d busy=%b, want wren=0 div=7 step=0 busy=0",
                         ok, wren_o, div_o, step_o, busy_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (wren_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_restart_load: got wren=%b busy=%b, want 0 1", wren_o, busy_o);
    end
    tick();
    checks++;
    if (wren_o !== 1'b1 || div_o !== 5'd3 || step_o !== 2'd0) begin
      errors++; $display("FAIL rst_restart: got wren=%b div=%0d step=%0d, want 1 3 0", wren_o, div_o, step_o);
    end
  endtask

  task automatic test_step_order();
    logic [1:0] exp_step[7];
    bit ok;
`ifdef LED_DIV_CTRL_PINGPONG_EN
    exp_step = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
`else
    exp_step = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif
    for (int p = 0; p < 7; p++) begin
      wait_pulse(100, ok);
      checks++;
      if (!ok || step_o !== exp_step[p]) begin
        errors++; $display("FAIL step_order %0d: got ok=%b step=%0d, want %0d", p, ok, step_o, exp_step[p]);
      end
    end
    checks++;
    if (b2b !== 1'b0) begin errors++; $display("FAIL back_to_back: got wren high two cycles running, want gap"); end
  endtask

  initial begin
    checks = 0; errors = 0;
    pend = 1'b0; hit = 1'b0; b2b = 1'b0; wren_prev = 1'b0;
    led_ph = 0; hits = 0; last_rises = 0;
    test_reset();
    test_seq();
    test_host_coincide();
    test_host_hold();
    test_disable();
    test_protocol();
    test_hold_zero();
    test_rst_mid();
    test_step_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
